// File: rtl/xor_scr_pkg.sv
// xor_scr_pkg: shared constants, state encoding and LFSR step for the 16-bit descrambler.
package xor_scr_pkg;
    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] SEED_DEF = 16'hACE1;
    localparam logic [WORD_W-1:0] POLY_DEF = 16'hB400;

    typedef enum logic {IDLE, FRAME} state_t;

    function automatic logic [WORD_W-1:0] lfsr_next(input logic [WORD_W-1:0] s, input logic [WORD_W-1:0] poly);
        return (s >> 1) ^ (s[0] ? poly : '0);
    endfunction
endpackage

// File: rtl/xor_descrambler16_if.sv
// xor_descrambler16_if: input stream, output stream and frame-check status bundle.
interface xor_descrambler16_if;
    import xor_scr_pkg::*;
    logic              in_valid, in_ready, in_sof, in_eof;
    logic [WORD_W-1:0] in_data;
    logic              out_valid, out_ready, out_last;
    logic [WORD_W-1:0] out_data;
    logic              chk_done, chk_err;
    logic [7:0]        err_cnt;

    modport master(
        output in_valid, in_data, in_sof, in_eof, out_ready,
        input  in_ready, out_valid, out_data, out_last, chk_done, chk_err, err_cnt
    );
    modport slave(
        input  in_valid, in_data, in_sof, in_eof, out_ready,
        output in_ready, out_valid, out_data, out_last, chk_done, chk_err, err_cnt
    );
endinterface

// File: rtl/lfsr16_keygen.sv
// lfsr16_keygen: Galois LFSR keystream; load forces SEED as the current key.
module lfsr16_keygen
    import xor_scr_pkg::*;
#(
    parameter logic [WORD_W-1:0] SEED = SEED_DEF,
    parameter logic [WORD_W-1:0] POLY = POLY_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              adv,
    output logic [WORD_W-1:0] key
);
    logic [WORD_W-1:0] lfsr;

    assign key = load ? SEED : lfsr;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr <= SEED;
        else if (adv) lfsr <= lfsr_next(key, POLY);
endmodule

// File: rtl/xor_descrambler16.sv
// xor_descrambler16: frame descrambler with registered output and XOR checksum verification.
module xor_descrambler16
    import xor_scr_pkg::*;
#(
    parameter logic [WORD_W-1:0] SEED = SEED_DEF,
    parameter logic [WORD_W-1:0] POLY = POLY_DEF
) (
    input logic                clk,
    input logic                rst_n,
    xor_descrambler16_if.slave bus
);
    state_t            state, state_nx;
    logic              acc, fwd, abort, mism, done_nx;
    logic [WORD_W-1:0] key, plain, csum;
    logic [8:0]        cnt_sum;

    lfsr16_keygen #(.SEED(SEED), .POLY(POLY)) u_keygen (
        .clk  (clk),
        .rst_n(rst_n),
        .load (acc && bus.in_sof),
        .adv  (fwd),
        .key  (key)
    );

    assign bus.in_ready = !bus.out_valid || bus.out_ready;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb state_nx = fwd ? (bus.in_eof ? IDLE : FRAME) : state;

    always_comb begin
        acc     = bus.in_valid && bus.in_ready;
        fwd     = acc && (bus.in_sof || state == FRAME);
        abort   = acc && bus.in_sof && state == FRAME;
        plain   = bus.in_data ^ key;
        mism    = plain != (bus.in_sof ? '0 : csum);
        done_nx = abort || (fwd && bus.in_eof);
        // an aborting sof+eof word counts both the abort and its own mismatch
        cnt_sum = {1'b0, bus.err_cnt} + 9'(abort) + 9'(fwd && bus.in_eof && mism);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            csum          <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            bus.chk_done  <= 1'b0;
            bus.chk_err   <= 1'b0;
            bus.err_cnt   <= '0;
        end else begin
            if (fwd) begin
                bus.out_data <= plain;
                bus.out_last <= bus.in_eof;
                csum         <= bus.in_eof ? '0 : (bus.in_sof ? '0 : csum) ^ plain;
            end
            bus.out_valid <= fwd || (bus.out_valid && !bus.out_ready);
            bus.chk_done  <= done_nx;
            bus.chk_err   <= done_nx && (bus.in_eof ? mism : 1'b1);
            bus.err_cnt   <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
        end
endmodule

// File: tb/tb_xor_descrambler16.sv
// tb_xor_descrambler16: directed and random frames against a frame-level reference model.
module tb_xor_descrambler16;
    import xor_scr_pkg::*;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] POLY = 16'hB400;

    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    xor_descrambler16_if bus();
    xor_descrambler16 #(.SEED(SEED), .POLY(POLY)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0, errors = 0;
    bit m_in_frame = 0;
    int m_idx = 0, m_errs = 0;
    logic [15:0] m_csum = 0;

    // key for the k-th word of a frame: k keystream steps from SEED
    function automatic logic [15:0] key_at(int k);
        logic [15:0] s = SEED;
        repeat (k) s = (s >> 1) ^ (s[0] ? POLY : 16'h0);
        return s;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(logic [15:0] d, bit sof, bit eof);
        bit fwd, done, err, mism;
        logic [15:0] plain;
        bus.in_data = d; bus.in_sof = sof; bus.in_eof = eof; bus.in_valid = 1;
        #1 check("in_ready", bus.in_ready, 1);
        fwd   = sof || m_in_frame;
        plain = d ^ key_at(sof ? 0 : m_idx);
        mism  = plain != (sof ? 16'h0 : m_csum);
        done  = (sof && m_in_frame) || (fwd && eof);
        err   = eof ? mism : 1'b1;
        if (sof && m_in_frame) m_errs++;
        if (fwd && eof && mism) m_errs++;
        if (m_errs > 255) m_errs = 255;
        if (fwd) begin
            if (eof) m_in_frame = 0;
            else begin
                m_csum = (sof ? 16'h0 : m_csum) ^ plain;
                m_idx = (sof ? 0 : m_idx) + 1;
                m_in_frame = 1;
            end
        end
        @(negedge clk);
        bus.in_valid = 0;
        check("out_valid", bus.out_valid, fwd);
        if (fwd) begin
            check("out_data", bus.out_data, plain);
            check("out_last", bus.out_last, eof);
        end
        check("chk_done", bus.chk_done, done);
        check("chk_err", bus.chk_err, done & err);
        check("err_cnt", bus.err_cnt, m_errs);
    endtask

    initial begin
        logic [15:0] p [4];
        logic [15:0] cs, w;
        int len, cut;
        bit bad;
        bus.in_valid = 0; bus.in_sof = 0; bus.in_eof = 0; bus.in_data = 0; bus.out_ready = 1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_chk_done", bus.chk_done, 0);
        check("rst_chk_err", bus.chk_err, 0);
        check("rst_err_cnt", bus.err_cnt, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst_n = 1;
        @(negedge clk);

        send(16'hBED5, 1, 0);
        check("two_w0", bus.out_data, 16'h1234);
        send(16'hF044, 0, 1);
        check("two_w1", bus.out_data, 16'h1234);
        check("two_err", bus.chk_err, 0);
        send(16'hACE1, 1, 1);
        check("single_data", bus.out_data, 16'h0000);
        check("single_done", bus.chk_done, 1);
        send(16'hBED5, 1, 0);
        send(16'hF045, 0, 1);
        check("bad_data", bus.out_data, 16'h1235);
        check("bad_cnt", bus.err_cnt, 1);
        send(16'hBED5, 1, 0);
        send(16'hBED5, 1, 0);
        check("abort_err", bus.chk_err, 1);
        check("abort_cnt", bus.err_cnt, 2);
        check("abort_data", bus.out_data, 16'h1234);
        send(key_at(1) ^ 16'h1234, 0, 1);
        send(16'h5555, 0, 0);
        send(16'h1111, 0, 1);

        @(negedge clk);
        for (int i = 0; i < 3; i++) p[i] = 16'($urandom);
        p[3] = p[0] ^ p[1] ^ p[2];
        bus.out_ready = 0;
        bus.in_data = p[0] ^ key_at(0); bus.in_sof = 1; bus.in_eof = 0; bus.in_valid = 1;
        @(negedge clk);
        check("bp_valid", bus.out_valid, 1);
        check("bp_data0", bus.out_data, p[0]);
        check("bp_ready", bus.in_ready, 0);
        bus.in_data = p[1] ^ key_at(1); bus.in_sof = 0;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_ready", bus.in_ready, 0);
            check("bp_hold_data", bus.out_data, p[0]);
        end
        bus.out_ready = 1;
        for (int i = 1; i < 4; i++) begin
            bus.in_data = p[i] ^ key_at(i); bus.in_eof = (i == 3);
            @(negedge clk);
            check("bp_data", bus.out_data, p[i]);
            check("bp_last", bus.out_last, i == 3);
        end
        bus.in_valid = 0; bus.in_eof = 0;
        check("bp_done", bus.chk_done, 1);
        check("bp_err", bus.chk_err, 0);
        @(negedge clk);

        send(16'hBED5, 1, 0);
        #2 rst_n = 0;
        #1;
        check("arst_valid", bus.out_valid, 0);
        check("arst_data", bus.out_data, 0);
        check("arst_cnt", bus.err_cnt, 0);
        m_in_frame = 0; m_errs = 0;
        @(negedge clk);
        rst_n = 1;
        check("arst_done", bus.chk_done, 0);
        send(16'hACE1, 1, 0);
        check("arst_seed", bus.out_data, 16'h0000);
        send(key_at(1), 0, 1);

        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 5);
            cut = (len > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, len - 1) : len;
            bad = $urandom_range(0, 3) == 0;
            cs = 0;
            for (int i = 0; i < cut; i++) begin
                w = (i == len - 1) ? cs ^ (bad ? 16'($urandom_range(1, 16'hFFFF)) : 16'h0) : 16'($urandom);
                cs ^= w;
                send(w ^ key_at(i), i == 0, i == len - 1);
            end
            if ($urandom_range(0, 5) == 0) send(16'($urandom), 0, $urandom_range(0, 1) == 1);
        end

        repeat (260) send(SEED ^ 16'h0001, 1, 1);
        check("sat_cnt", bus.err_cnt, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
